// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter that shares the DDR controller's access port between NPORTS requesters.
// Each grant covers one whole transaction (one write, or a full read burst) plus the controller's drain.
module ddr_port_arbiter #(
   parameter int NPORTS    = 2,
   parameter int BUF_WIDTH = 3
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic [NPORTS-1:0]    req_acc_i,
   input  logic [NPORTS-1:0]    req_we_i,
   input  logic [NPORTS*32-1:0] req_adr_i,
   input  logic [NPORTS*32-1:0] req_dat_i,
   input  logic [NPORTS*4-1:0]  req_sel_i,
   output logic [NPORTS-1:0]    req_ack_o,
   output logic [31:0]          req_dat_o,
   output logic [31:0]          req_adr_o,
   output logic [NPORTS-1:0]    grant_o,
   output logic                 ctrl_acc_o,
   output logic                 ctrl_we_o,
   output logic [31:0]          ctrl_adr_o,
   output logic [31:0]          ctrl_dat_o,
   output logic [3:0]           ctrl_sel_o,
   output logic [3:0]           ctrl_buf_width_o,
   input  logic                 ctrl_ack_i,
   input  logic [31:0]          ctrl_dat_i,
   input  logic [31:0]          ctrl_adr_i,
   input  logic                 ctrl_idle_i,
   input  logic                 ctrl_rdy_i
);

   localparam int IDXW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int CW   = BUF_WIDTH + 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'((1 << BUF_WIDTH) - 1);

   typedef enum logic [1:0] {ARB, BUSY, DRAIN} state_t;

   state_t            state, state_next;
   logic [IDXW-1:0]   last_idx, gnt_idx, pick_idx, cand;
   logic [NPORTS-1:0] pick_onehot;
   logic              pick_valid;
   logic [CW-1:0]     beat_cnt;
   logic              start, beat, done;

   logic              we_arr  [NPORTS];
   logic [31:0]       adr_arr [NPORTS];
   logic [31:0]       dat_arr [NPORTS];
   logic [3:0]        sel_arr [NPORTS];

   for (genvar p = 0; p < NPORTS; p++) begin : g_unpack
      assign we_arr[p]  = req_we_i[p];
      assign adr_arr[p] = req_adr_i[32*p +: 32];
      assign dat_arr[p] = req_dat_i[32*p +: 32];
      assign sel_arr[p] = req_sel_i[4*p +: 4];
   end

   assign ctrl_buf_width_o = 4'(BUF_WIDTH);

   // Scan downwards so the requester closest after the last owner is the one that sticks.
   always_comb begin
      pick_valid  = 1'b0;
      pick_idx    = '0;
      cand        = '0;
      pick_onehot = '0;
      for (int i = NPORTS; i >= 1; i--) begin
         cand = IDXW'((int'(last_idx) + i) % NPORTS);
         if (req_acc_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
      pick_onehot[pick_idx] = 1'b1;
   end

   assign start = (state == ARB) && pick_valid && ctrl_idle_i && ctrl_rdy_i;
   assign beat  = (state == BUSY) && ctrl_ack_i;
   assign done  = beat && (ctrl_we_o || (beat_cnt == LAST_BEAT));

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= DRAIN;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ARB:     if (start)       state_next = BUSY;
         BUSY:    if (done)        state_next = DRAIN;
         DRAIN:   if (ctrl_idle_i) state_next = ARB;
         default:                  state_next = DRAIN;
      endcase
   end

   // Acks and read data only reach the owner, and only while it still wants them.
   always_comb begin
      req_ack_o = '0;
      req_dat_o = '0;
      req_adr_o = '0;
      if (beat) begin
         req_ack_o = grant_o & req_acc_i;
         if (!ctrl_we_o) begin
            req_dat_o = ctrl_dat_i;
            req_adr_o = ctrl_adr_i;
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         grant_o    <= '0;
         gnt_idx    <= '0;
         last_idx   <= IDXW'(NPORTS - 1);
         ctrl_acc_o <= 1'b0;
         ctrl_we_o  <= 1'b0;
         ctrl_adr_o <= '0;
         ctrl_dat_o <= '0;
         ctrl_sel_o <= '0;
         beat_cnt   <= '0;
      end else begin
         if (start) begin
            grant_o    <= pick_onehot;
            gnt_idx    <= pick_idx;
            ctrl_acc_o <= 1'b1;
            ctrl_we_o  <= we_arr[pick_idx];
            ctrl_adr_o <= adr_arr[pick_idx];
            ctrl_dat_o <= dat_arr[pick_idx];
            ctrl_sel_o <= sel_arr[pick_idx];
            beat_cnt   <= '0;
         end else if (done) begin
            ctrl_acc_o <= 1'b0;
         end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         // A DRAIN entered from reset has no owner, so the rotation point is left alone.
         if (state == DRAIN && ctrl_idle_i) begin
            grant_o <= '0;
            if (|grant_o) last_idx <= gnt_idx;
         end
      end
   end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: directed transactions push expected grants/acks,
// a negedge monitor pops and compares whenever the DUT grants or acks.
module tb_ddr_port_arbiter;

   localparam int NPORTS    = 2;
   localparam int BUF_WIDTH = 3;
   localparam int BEATS     = 8;

   logic                 wb_clk_i = 1'b0;
   logic                 wb_rst_i;
   logic [NPORTS-1:0]    req_acc_i, req_we_i;
   logic [NPORTS*32-1:0] req_adr_i, req_dat_i;
   logic [NPORTS*4-1:0]  req_sel_i;
   logic [NPORTS-1:0]    req_ack_o, grant_o;
   logic [31:0]          req_dat_o, req_adr_o;
   logic                 ctrl_acc_o, ctrl_we_o;
   logic [31:0]          ctrl_adr_o, ctrl_dat_o;
   logic [3:0]           ctrl_sel_o, ctrl_buf_width_o;
   logic                 ctrl_ack_i, ctrl_idle_i, ctrl_rdy_i;
   logic [31:0]          ctrl_dat_i, ctrl_adr_i;

   typedef struct {
      logic [1:0]  mask;
      logic        chk_data;
      logic [31:0] dat;
      logic [31:0] adr;
   } ack_t;

   typedef struct {
      logic [1:0]  grant;
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } gnt_t;

   ack_t       exp_ack[$];
   gnt_t       exp_gnt[$];
   int         checks = 0;
   int         errors = 0;
   logic [1:0] prev_grant = 2'b00;

   ddr_port_arbiter #(.NPORTS(NPORTS), .BUF_WIDTH(BUF_WIDTH)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .req_acc_i(req_acc_i), .req_we_i(req_we_i), .req_adr_i(req_adr_i),
      .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
      .req_ack_o(req_ack_o), .req_dat_o(req_dat_o), .req_adr_o(req_adr_o),
      .grant_o(grant_o),
      .ctrl_acc_o(ctrl_acc_o), .ctrl_we_o(ctrl_we_o), .ctrl_adr_o(ctrl_adr_o),
      .ctrl_dat_o(ctrl_dat_o), .ctrl_sel_o(ctrl_sel_o), .ctrl_buf_width_o(ctrl_buf_width_o),
      .ctrl_ack_i(ctrl_ack_i), .ctrl_dat_i(ctrl_dat_i), .ctrl_adr_i(ctrl_adr_i),
      .ctrl_idle_i(ctrl_idle_i), .ctrl_rdy_i(ctrl_rdy_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic p, input logic acc, input logic we,
                                input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      req_acc_i[p]          = acc;
      req_we_i[p]           = we;
      req_adr_i[p*32 +: 32] = adr;
      req_dat_i[p*32 +: 32] = dat;
      req_sel_i[p*4 +: 4]   = sel;
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic push_gnt(input logic [1:0] g, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
      gnt_t e;
      e.grant = g; e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
      exp_gnt.push_back(e);
   endtask

   task automatic push_ack(input logic [1:0] m, input logic chk, input logic [31:0] dat, input logic [31:0] adr);
      ack_t e;
      e.mask = m; e.chk_data = chk; e.dat = dat; e.adr = adr;
      exp_ack.push_back(e);
   endtask

   task automatic wait_grant();
      int n = 0;
      do begin
         @(negedge wb_clk_i);
         n++;
      end while (!ctrl_acc_o && n < 40);
      checkOutput("grant_seen", 32'(ctrl_acc_o), 32'h1);
   endtask

   task automatic serve_write(input logic p, input logic [1:0] drop);
      push_ack(p ? 2'b10 : 2'b01, 1'b0, 32'h0, 32'h0);
      tick();
      ctrl_idle_i = 1'b0;
      ctrl_ack_i  = 1'b1;
      tick();
      ctrl_ack_i  = 1'b0;
      req_acc_i   = req_acc_i & ~drop;
      ctrl_idle_i = 1'b1;
   endtask

   // Leaves ctrl_idle_i low so the caller decides when the controller drains.
   task automatic serve_read(input logic p, input logic [31:0] base, input int drop_after);
      ctrl_idle_i = 1'b0;
      for (int b = 0; b < BEATS; b++) begin
         tick();
         ctrl_ack_i = 1'b1;
         ctrl_dat_i = 32'(b);
         ctrl_adr_i = base + 32'(4 * b);
         if (b == drop_after) req_acc_i[p] = 1'b0;
         if (b < drop_after) push_ack(p ? 2'b10 : 2'b01, 1'b1, 32'(b), base + 32'(4 * b));
         @(negedge wb_clk_i);
         checkOutput("acc_during_burst", 32'(ctrl_acc_o), 32'h1);
      end
      tick();
      ctrl_ack_i   = 1'b0;
      req_acc_i[p] = 1'b0;
      @(negedge wb_clk_i);
      checkOutput("acc_low_after_burst", 32'(ctrl_acc_o), 32'h0);
   endtask

   always @(negedge wb_clk_i) begin
      if (grant_o != 2'b00 && grant_o != prev_grant) begin
         if (exp_gnt.size() == 0) begin
            checkOutput("unexpected_grant", 32'(grant_o), 32'h0);
         end else begin
            gnt_t e;
            e = exp_gnt.pop_front();
            checkOutput("grant_owner", 32'(grant_o), 32'(e.grant));
            checkOutput("ctrl_acc", 32'(ctrl_acc_o), 32'h1);
            checkOutput("ctrl_we", 32'(ctrl_we_o), 32'(e.we));
            checkOutput("ctrl_adr", ctrl_adr_o, e.adr);
            checkOutput("ctrl_dat", ctrl_dat_o, e.dat);
            checkOutput("ctrl_sel", 32'(ctrl_sel_o), 32'(e.sel));
         end
      end
      prev_grant = grant_o;
      if (req_ack_o != 2'b00) begin
         if (exp_ack.size() == 0) begin
            checkOutput("unexpected_ack", 32'(req_ack_o), 32'h0);
         end else begin
            ack_t e;
            e = exp_ack.pop_front();
            checkOutput("ack_mask", 32'(req_ack_o), 32'(e.mask));
            if (e.chk_data) begin
               checkOutput("read_dat", req_dat_o, e.dat);
               checkOutput("read_adr", req_adr_o, e.adr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      errors++;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      // Test 1: reset with random inputs
      wb_rst_i    = 1'b1;
      req_acc_i   = 2'($urandom);
      req_we_i    = 2'($urandom);
      req_adr_i   = {$urandom, $urandom};
      req_dat_i   = {$urandom, $urandom};
      req_sel_i   = 8'($urandom);
      ctrl_ack_i  = 1'($urandom);
      ctrl_dat_i  = $urandom;
      ctrl_adr_i  = $urandom;
      ctrl_idle_i = 1'($urandom);
      ctrl_rdy_i  = 1'($urandom);
      repeat (3) @(negedge wb_clk_i);
      checkOutput("rst_grant", 32'(grant_o), 32'h0);
      checkOutput("rst_req_ack", 32'(req_ack_o), 32'h0);
      checkOutput("rst_req_dat", req_dat_o, 32'h0);
      checkOutput("rst_req_adr", req_adr_o, 32'h0);
      checkOutput("rst_ctrl_acc", 32'(ctrl_acc_o), 32'h0);
      checkOutput("rst_ctrl_we", 32'(ctrl_we_o), 32'h0);
      checkOutput("rst_ctrl_adr", ctrl_adr_o, 32'h0);
      checkOutput("rst_ctrl_dat", ctrl_dat_o, 32'h0);
      checkOutput("rst_ctrl_sel", 32'(ctrl_sel_o), 32'h0);
      checkOutput("rst_buf_width", 32'(ctrl_buf_width_o), 32'h3);

      req_acc_i = '0; req_we_i = '0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
      ctrl_ack_i = 1'b0; ctrl_dat_i = '0; ctrl_adr_i = '0;
      ctrl_idle_i = 1'b1; ctrl_rdy_i = 1'b0;
      tick();
      wb_rst_i = 1'b0;

      // Test 2: port0 write, first held off by ctrl_rdy_i low
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
      repeat (3) begin
         tick();
         checkOutput("no_grant_rdy_low", 32'(grant_o), 32'h0);
      end
      push_gnt(2'b01, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
      ctrl_rdy_i = 1'b1;
      wait_grant();
      serve_write(1'b0, 2'b01);

      // Test 3: port1 eight-beat read
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0124, 32'h0, 4'hF);
      push_gnt(2'b10, 1'b0, 32'h0000_0124, 32'h0, 4'hF);
      wait_grant();
      serve_read(1'b1, 32'h0000_0124, BEATS);
      checkOutput("grant_held_drain", 32'(grant_o), 32'h2);
      ctrl_idle_i = 1'b1;
      tick();
      checkOutput("grant_clear_idle", 32'(grant_o), 32'h0);

      // Test 4: both ports write continuously, strict rotation
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 4'h3);
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) push_gnt(2'b01, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
         else            push_gnt(2'b10, 1'b1, 32'h0000_0300, 32'h1234_5678, 4'h3);
      end
      for (int k = 0; k < 6; k++) begin
         wait_grant();
         serve_write(1'(k % 2), (k == 5) ? 2'b11 : 2'b00);
      end

      // Test 5: port1 read dropped after beat 3, port0 waiting
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0140, 32'h0, 4'hF);
      push_gnt(2'b10, 1'b0, 32'h0000_0140, 32'h0, 4'hF);
      wait_grant();
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'h5);
      push_gnt(2'b01, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'h5);
      serve_read(1'b1, 32'h0000_0140, 3);
      ctrl_idle_i = 1'b1;
      wait_grant();
      serve_write(1'b0, 2'b01);

      // Test 6: reset at beat 4 of a read, controller keeps bursting with idle low
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0180, 32'h0, 4'hF);
      push_gnt(2'b10, 1'b0, 32'h0000_0180, 32'h0, 4'hF);
      wait_grant();
      ctrl_idle_i = 1'b0;
      for (int b = 0; b < 3; b++) begin
         tick();
         ctrl_ack_i = 1'b1;
         ctrl_dat_i = 32'(b);
         ctrl_adr_i = 32'h0000_0180 + 32'(4 * b);
         push_ack(2'b10, 1'b1, 32'(b), 32'h0000_0180 + 32'(4 * b));
      end
      tick();
      ctrl_dat_i = 32'h3;
      ctrl_adr_i = 32'h0000_018C;
      wb_rst_i   = 1'b1;
      req_acc_i[1] = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 4'hC);
      push_gnt(2'b01, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 4'hC);
      @(negedge wb_clk_i);
      checkOutput("midrst_grant", 32'(grant_o), 32'h0);
      checkOutput("midrst_acc", 32'(ctrl_acc_o), 32'h0);
      checkOutput("midrst_ack", 32'(req_ack_o), 32'h0);
      checkOutput("midrst_ctrl_adr", ctrl_adr_o, 32'h0);
      tick();
      wb_rst_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         ctrl_ack_i = (c < 4);
         ctrl_dat_i = 32'(4 + c);
         @(negedge wb_clk_i);
         checkOutput("no_grant_idle_low", 32'(grant_o), 32'h0);
         tick();
      end
      ctrl_ack_i  = 1'b0;
      ctrl_idle_i = 1'b1;
      tick();
      checkOutput("no_grant_drain_exit", 32'(grant_o), 32'h0);
      tick();
      checkOutput("grant_after_idle", 32'(grant_o), 32'h1);
      serve_write(1'b0, 2'b01);

      repeat (4) tick();
      checkOutput("gnt_queue_empty", 32'(exp_gnt.size()), 32'h0);
      checkOutput("ack_queue_empty", 32'(exp_ack.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
